// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: per-register hold/flush strobes,
// multi-cycle EX op tracking and memory wait-state timeout.
module pipe_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int MC_CNT_W  = 6,
    parameter int TIMEOUT   = 8,
    parameter int TO_CNT_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_use_i,
    input  logic       branch_i,
    input  logic       mc_start_i,
    input  logic       mem_wait_i,
    input  logic       trap_i,
    output logic [4:0] hold_o,
    output logic [4:0] flush_o,
    output logic       mc_kill_o,
    output logic       mc_done_o,
    output logic       bus_err_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        TRAP    = 2'd2
    } state_t;

    localparam logic [4:0] H_MEM  = 5'b01111;
    localparam logic [4:0] F_MEM  = 5'b10000;
    localparam logic [4:0] H_MC   = 5'b00111;
    localparam logic [4:0] F_MC   = 5'b01000;
    localparam logic [4:0] F_TRAP = 5'b01110;
    localparam logic [4:0] F_BR   = 5'b00110;
    localparam logic [4:0] H_LU   = 5'b00011;
    localparam logic [4:0] F_LU   = 5'b00100;

    state_t                state_q, state_d;
    logic [MC_CNT_W-1:0]   mc_cnt_q, mc_cnt_d;
    logic [TO_CNT_W-1:0]   to_cnt_q, to_cnt_d;
    logic                  bus_err_q, bus_err_d;
    logic [4:0]            raw_hold;
    logic [4:0]            flush;
    logic                  kill;
    logic                  done;

    always_comb begin
        raw_hold = 5'b00000;
        flush    = 5'b00000;
        kill     = 1'b0;
        done     = 1'b0;
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        case (state_q)
            RUN: begin
                if (trap_i) begin
                    flush   = F_TRAP;
                    state_d = TRAP;
                end else if (mem_wait_i) begin
                    raw_hold = H_MEM;
                    flush    = F_MEM;
                end else if (mc_start_i) begin
                    raw_hold = H_MC;
                    flush    = F_MC;
                    mc_cnt_d = MC_CNT_W'(MC_CYCLES - 1);
                    state_d  = MC_WAIT;
                end else if (branch_i) begin
                    flush = F_BR;
                end else if (ld_use_i) begin
                    raw_hold = H_LU;
                    flush    = F_LU;
                end
            end
            MC_WAIT: begin
                if (trap_i) begin
                    kill     = 1'b1;
                    flush    = F_TRAP;
                    mc_cnt_d = '0;
                    state_d  = TRAP;
                end else if (mem_wait_i) begin
                    // The divider keeps running while MEM stalls; done is deferred to release
                    raw_hold = H_MEM;
                    flush    = F_MEM;
                    mc_cnt_d = (mc_cnt_q != '0) ? mc_cnt_q - 1'b1 : '0;
                end else if (mc_cnt_q != '0) begin
                    raw_hold = H_MC;
                    flush    = F_MC;
                    mc_cnt_d = mc_cnt_q - 1'b1;
                end else begin
                    done    = 1'b1;
                    state_d = RUN;
                end
            end
            TRAP: begin
                if (trap_i) begin
                    flush   = F_TRAP;
                    state_d = TRAP;
                end else if (mem_wait_i) begin
                    raw_hold = 5'b01101;
                    flush    = 5'b10010;
                    state_d  = RUN;
                end else begin
                    flush   = 5'b00010;
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    // Counter parks one past the trigger value so a long wait fires only once
    always_comb begin
        to_cnt_d  = to_cnt_q;
        bus_err_d = 1'b0;
        if (!mem_wait_i) begin
            to_cnt_d = '0;
        end else begin
            if (to_cnt_q != TO_CNT_W'(TIMEOUT)) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
            bus_err_d = (to_cnt_q == TO_CNT_W'(TIMEOUT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mc_cnt_q  <= '0;
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_cnt_q  <= mc_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign hold_o    = raw_hold & ~flush;
    assign flush_o   = flush;
    assign mc_kill_o = kill;
    assign mc_done_o = done;
    assign bus_err_o = bus_err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: time-stamp based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_pipe_ctrl;

    localparam int MC_CYCLES = 4;
    localparam int TIMEOUT   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_use_i = 1'b0, branch_i = 1'b0, mc_start_i = 1'b0;
    logic       mem_wait_i = 1'b0, trap_i = 1'b0;
    logic [4:0] hold_o, flush_o;
    logic       mc_kill_o, mc_done_o, bus_err_o;
    logic [1:0] state_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.MC_CYCLES(MC_CYCLES), .MC_CNT_W(6), .TIMEOUT(TIMEOUT), .TO_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_use_i(ld_use_i), .branch_i(branch_i), .mc_start_i(mc_start_i),
        .mem_wait_i(mem_wait_i), .trap_i(trap_i),
        .hold_o(hold_o), .flush_o(flush_o), .mc_kill_o(mc_kill_o),
        .mc_done_o(mc_done_o), .bus_err_o(bus_err_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Model: mode 0=RUN 1=MC_WAIT 2=TRAP; the divider result is ready at an absolute cycle number
    int m_mode = 0;
    int m_cyc = 0;
    int m_ready = 0;
    int m_wlen = 0;
    bit m_berr = 1'b0;

    function automatic logic [15:0] model_out(input int mode, input bit ready,
                                              input bit lu, br, mcs, mw, tr);
        logic [4:0] h, f;
        logic k, d;
        h = '0; f = '0; k = 0; d = 0;
        if (mode == 0) begin
            if (tr)       f = 5'b01110;
            else if (mw)  begin h = 5'b01111; f = 5'b10000; end
            else if (mcs) begin h = 5'b00111; f = 5'b01000; end
            else if (br)  f = 5'b00110;
            else if (lu)  begin h = 5'b00011; f = 5'b00100; end
        end else if (mode == 1) begin
            if (tr)          begin k = 1; f = 5'b01110; end
            else if (mw)     begin h = 5'b01111; f = 5'b10000; end
            else if (!ready) begin h = 5'b00111; f = 5'b01000; end
            else             d = 1;
        end else begin
            if (tr)       f = 5'b01110;
            else if (mw)  begin h = 5'b01101; f = 5'b10010; end
            else          f = 5'b00010;
        end
        model_out = {h & ~f, f, 2'(mode), k, d, 1'b0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ready = 0; m_wlen = 0; m_berr = 0;
        end else begin
            m_berr = mem_wait_i && (m_wlen + 1 == TIMEOUT);
            m_wlen = mem_wait_i ? m_wlen + 1 : 0;
            case (m_mode)
                0: if (trap_i) m_mode = 2;
                   else if (!mem_wait_i && mc_start_i) begin
                       m_mode = 1; m_ready = m_cyc + MC_CYCLES;
                   end
                1: if (trap_i) m_mode = 2;
                   else if (!mem_wait_i && m_cyc >= m_ready) m_mode = 0;
                default: m_mode = trap_i ? 2 : 0;
            endcase
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp_v, act_v;
        exp_v = model_out(m_mode, m_cyc >= m_ready, ld_use_i, branch_i, mc_start_i,
                          mem_wait_i, trap_i);
        exp_v[0] = m_berr;
        act_v = {hold_o, flush_o, state_o, mc_kill_o, mc_done_o, bus_err_o};
        checks = checks + 1;
        if (act_v !== exp_v) begin
            failures = failures + 1;
            $display("FAIL model t=%0t {hold,flush,state,kill,done,berr} got=%b exp=%b",
                     $time, act_v, exp_v);
        end
    end

    task automatic drive(input bit lu, input bit br, input bit mcs, input bit mw, input bit tr);
        @(posedge clk);
        #1;
        ld_use_i = lu; branch_i = br; mc_start_i = mcs; mem_wait_i = mw; trap_i = tr;
    endtask

    task automatic lit(input string name, input logic [4:0] h, input logic [4:0] f,
                       input logic [1:0] st, input bit k, input bit d, input bit be);
        logic [15:0] act_v, exp_v;
        @(negedge clk);
        #1;
        exp_v = {h, f, st, k, d, be};
        act_v = {hold_o, flush_o, state_o, mc_kill_o, mc_done_o, bus_err_o};
        checks = checks + 1;
        if (act_v !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s got=%b exp=%b", name, act_v, exp_v);
        end
    endtask

    initial begin
        int mw_left;
        bit mw;
        #23;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0); lit("reset_idle", 5'b0, 5'b0, 2'd0, 0, 0, 0);
        end

        drive(0, 0, 1, 0, 0); lit("mc_c0", 5'b00111, 5'b01000, 2'd0, 0, 0, 0);
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 0); lit("mc_wait", 5'b00111, 5'b01000, 2'd1, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0); lit("mc_done", 5'b0, 5'b0, 2'd1, 0, 1, 0);
        drive(0, 0, 0, 0, 0); lit("mc_back_run", 5'b0, 5'b0, 2'd0, 0, 0, 0);

        drive(1, 1, 0, 0, 0); lit("br_ld", 5'b0, 5'b00110, 2'd0, 0, 0, 0);
        drive(1, 0, 0, 0, 0); lit("ld_only", 5'b00011, 5'b00100, 2'd0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 0);
            lit("mem_wait", 5'b01111, 5'b10000, 2'd0, 0, 0, (i == 8));
        end
        drive(0, 0, 0, 0, 0); lit("mw_release", 5'b0, 5'b0, 2'd0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        checks = checks + 1;
        if (dut.to_cnt_q !== 8'd0) begin
            failures = failures + 1;
            $display("FAIL to_cnt_clear got=%0d exp=0", dut.to_cnt_q);
        end

        drive(0, 0, 1, 0, 0); lit("mck_c0", 5'b00111, 5'b01000, 2'd0, 0, 0, 0);
        drive(0, 0, 0, 0, 0); lit("mck_c1", 5'b00111, 5'b01000, 2'd1, 0, 0, 0);
        drive(0, 0, 0, 0, 1); lit("mck_kill", 5'b0, 5'b01110, 2'd1, 1, 0, 0);
        drive(0, 0, 0, 0, 0); lit("mck_trap", 5'b0, 5'b00010, 2'd2, 0, 0, 0);
        drive(0, 0, 0, 0, 0); lit("mck_run", 5'b0, 5'b0, 2'd0, 0, 0, 0);

        drive(0, 0, 1, 0, 0); lit("mcw_c0", 5'b00111, 5'b01000, 2'd0, 0, 0, 0);
        drive(0, 0, 0, 0, 0); lit("mcw_c1", 5'b00111, 5'b01000, 2'd1, 0, 0, 0);
        drive(0, 0, 0, 0, 0); lit("mcw_c2", 5'b00111, 5'b01000, 2'd1, 0, 0, 0);
        for (int i = 3; i < 7; i++) begin
            drive(0, 0, 0, 1, 0); lit("mcw_mem", 5'b01111, 5'b10000, 2'd1, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0); lit("mcw_done", 5'b0, 5'b0, 2'd1, 0, 1, 0);
        drive(0, 0, 0, 0, 0); lit("mcw_run", 5'b0, 5'b0, 2'd0, 0, 0, 0);

        drive(0, 0, 0, 0, 1); lit("trap_run", 5'b0, 5'b01110, 2'd0, 0, 0, 0);
        drive(0, 0, 0, 0, 1); lit("trap_again", 5'b0, 5'b01110, 2'd2, 0, 0, 0);
        drive(0, 1, 1, 1, 0); lit("trap_mw", 5'b01101, 5'b10010, 2'd2, 0, 0, 0);
        drive(0, 0, 0, 0, 0); lit("trap_exit", 5'b0, 5'b0, 2'd0, 0, 0, 0);

        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({hold_o, flush_o, state_o, mc_kill_o, mc_done_o, bus_err_o} !== 15'd0) begin
            failures = failures + 1;
            $display("FAIL async_reset got=%b exp=0",
                     {hold_o, flush_o, state_o, mc_kill_o, mc_done_o, bus_err_o});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        mw_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (mw_left == 0 && $urandom_range(0, 4) == 0) mw_left = $urandom_range(1, 12);
            mw = (mw_left != 0);
            if (mw_left != 0) mw_left = mw_left - 1;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, mw, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #3;
                rst_n = 1'b0;
                ld_use_i = 0; branch_i = 0; mc_start_i = 0; mem_wait_i = 0; trap_i = 0;
                mw_left = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        drive(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
